// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, FSM states, op classifiers.
// MDU_MADD_EN enables the multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU).
package mdu_pkg;

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;
   localparam logic [3:0] OP_MADD  = 4'd9;
   localparam logic [3:0] OP_MADDU = 4'd10;
   localparam logic [3:0] OP_MSUB  = 4'd11;
   localparam logic [3:0] OP_MSUBU = 4'd12;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   // Ops that occupy the unit for MULT_CYCLES
   function automatic logic is_mult(input logic [3:0] op);
`ifdef MDU_MADD_EN
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
             (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`else
      return (op == OP_MULT) || (op == OP_MULTU);
`endif
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational arithmetic for the MDU: 64-bit products, truncating divide, divide-by-zero flag.
// MDU_MADD_EN adds the {HI,LO} accumulator inputs and the 64-bit add/subtract.
module mdu_core
   import mdu_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
`ifdef MDU_MADD_EN
   input  logic [31:0] hi,
   input  logic [31:0] lo,
`endif
   output logic [31:0] hi_res,
   output logic [31:0] lo_res,
   output logic        div_zero
);

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [63:0] res;
   logic        sgn;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] b_safe;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] q;
   logic [31:0] r;

   always_comb begin
      prod_s   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      prod_u   = {32'd0, a} * {32'd0, b};
      // One unsigned divider serves both DIV and DIVU; signs are restored afterwards,
      // which also yields 0x80000000 / -1 = 0x80000000 rem 0 without special casing.
      sgn      = (op == OP_DIV);
      a_mag    = (sgn && a[31]) ? (32'd0 - a) : a;
      b_mag    = (sgn && b[31]) ? (32'd0 - b) : b;
      b_safe   = (b == 32'd0) ? 32'd1 : b_mag;
      q_mag    = a_mag / b_safe;
      r_mag    = a_mag % b_safe;
      q        = (sgn && (a[31] ^ b[31])) ? (32'd0 - q_mag) : q_mag;
      r        = (sgn && a[31]) ? (32'd0 - r_mag) : r_mag;
      res      = 64'd0;
      div_zero = 1'b0;
      case (op)
         OP_MULT:  res = prod_s;
         OP_MULTU: res = prod_u;
         OP_DIV, OP_DIVU: begin
            res      = {r, q};
            div_zero = (b == 32'd0);
         end
`ifdef MDU_MADD_EN
         OP_MADD:  res = {hi, lo} + prod_s;
         OP_MADDU: res = {hi, lo} + prod_u;
         OP_MSUB:  res = {hi, lo} - prod_s;
         OP_MSUBU: res = {hi, lo} - prod_u;
`endif
         default:  res = 64'd0;
      endcase
   end

   assign hi_res = res[63:32];
   assign lo_res = res[31:0];

endmodule

// File: rtl/mdu_hilo.sv
// EX-stage multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU accumulation into {HI,LO}.
//
// state  | meaning
// S_IDLE | accepts MT*/mult/div on start; HI/LO hold architectural values
// S_BUSY | result waits in pending regs; counter runs down to 1, then retires
module mdu_hilo
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HILOout,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [31:0]   pend_hi, pend_hi_nx;
   logic [31:0]   pend_lo, pend_lo_nx;
   logic          pend_dz, pend_dz_nx;
   logic [31:0]   hi_nx, lo_nx;
   logic [31:0]   core_hi, core_lo;
   logic          core_dz;

   mdu_core u_core (
      .op       (op),
      .a        (A),
      .b        (B),
`ifdef MDU_MADD_EN
      .hi       (HI),
      .lo       (LO),
`endif
      .hi_res   (core_hi),
      .lo_res   (core_lo),
      .div_zero (core_dz)
   );

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      pend_hi_nx = pend_hi;
      pend_lo_nx = pend_lo;
      pend_dz_nx = pend_dz;
      hi_nx      = HI;
      lo_nx      = LO;
      if (state == S_IDLE) begin
         if (start) begin
            if (is_mult(op) || is_div(op)) begin
               pend_hi_nx = core_hi;
               pend_lo_nx = core_lo;
               pend_dz_nx = core_dz;
               cnt_nx     = is_div(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
               state_nx   = S_BUSY;
            end else if (op == OP_MTHI) begin
               hi_nx = A;
            end else if (op == OP_MTLO) begin
               lo_nx = A;
            end
         end
      end else begin
         cnt_nx = cnt - CW'(1);
         if (cnt == CW'(1)) begin
            state_nx = S_IDLE;
            // Divide by zero retires without touching HI/LO
            if (!pend_dz) begin
               hi_nx = pend_hi;
               lo_nx = pend_lo;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
         pend_dz <= 1'b0;
         HI      <= 32'd0;
         LO      <= 32'd0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         pend_hi <= pend_hi_nx;
         pend_lo <= pend_lo_nx;
         pend_dz <= pend_dz_nx;
         HI      <= hi_nx;
         LO      <= lo_nx;
      end
   end

   assign busy    = (state == S_BUSY);
   assign HILOout = (op == OP_MFHI) ? HI : (op == OP_MFLO) ? LO : 32'd0;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed cases plus randomized ops against an arithmetic model.
module tb_mdu_hilo;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] HILOout;
   logic [31:0] HI;
   logic [31:0] LO;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   mdu_hilo #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .A       (A),
      .B       (B),
      .busy    (busy),
      .HILOout (HILOout),
      .HI      (HI),
      .LO      (LO)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Architectural effect of one accepted op on {HI,LO}
   function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] hi,
                                         input logic [31:0] lo);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      r  = {hi, lo};
      case (o)
         4'd1: r = sa * sb;
         4'd2: r = ua * ub;
         4'd3: if (b != 32'd0) r = {32'(sa % sb), 32'(sa / sb)};
         4'd4: if (b != 32'd0) r = {32'(ua % ub), 32'(ua / ub)};
         4'd5: r[63:32] = a;
         4'd6: r[31:0]  = a;
`ifdef MDU_MADD_EN
         4'd9:  r = {hi, lo} + 64'(sa * sb);
         4'd10: r = {hi, lo} + ua * ub;
         4'd11: r = {hi, lo} - 64'(sa * sb);
         4'd12: r = {hi, lo} - ua * ub;
`endif
         default: ;
      endcase
      return r;
   endfunction

   function automatic int cycles(input logic [3:0] o);
      if (o == 4'd1 || o == 4'd2) return MC;
      if (o == 4'd3 || o == 4'd4) return DC;
`ifdef MDU_MADD_EN
      if (o >= 4'd9 && o <= 4'd12) return MC;
`endif
      return 0;
   endfunction

   // Called at a negedge; issues one op, counts busy cycles, checks the retired HI/LO.
   // A nonzero inject fires a stray MULTU start on that busy cycle.
   task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input string tag, input int inject);
      int          cnt;
      logic [63:0] exp;
      exp   = model(o, a, b, m_hi, m_lo);
      start = 1'b1;
      op    = o;
      A     = a;
      B     = b;
      @(negedge clk);
      start = 1'b0;
      op    = 4'd0;
      A     = $urandom;
      B     = $urandom;
      cnt   = 0;
      while (busy === 1'b1 && cnt < 100) begin
         cnt++;
         if (cnt == inject) begin
            start = 1'b1;
            op    = 4'd2;
            A     = $urandom;
            B     = $urandom;
         end else begin
            start = 1'b0;
            op    = 4'd0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      op    = 4'd0;
      check({tag, " busy_cycles"}, cnt, cycles(o));
      m_hi = exp[63:32];
      m_lo = exp[31:0];
      check({tag, " HI"}, HI, m_hi);
      check({tag, " LO"}, LO, m_lo);
   endtask

   task automatic check_mf(input string tag);
      op = 4'd7;
      #1 check({tag, " MFHI"}, HILOout, m_hi);
      op = 4'd8;
      #1 check({tag, " MFLO"}, HILOout, m_lo);
      op = 4'd0;
      #1 check({tag, " HILOout_nop"}, HILOout, 32'd0);
   endtask

   initial begin
      logic [3:0]  ro;
      logic [31:0] ra, rb;
      reset = 1'b1;
      start = 1'b0;
      op    = 4'd0;
      A     = 32'd0;
      B     = 32'd0;
      m_hi  = 32'd0;
      m_lo  = 32'd0;
      repeat (2) @(negedge clk);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset HI", HI, 32'd0);
      check("reset LO", LO, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      run_op(4'd1, 32'hFFFFFFFE, 32'd3, "mult", 0);
      check("mult HI const", HI, 32'hFFFFFFFF);
      check("mult LO const", LO, 32'hFFFFFFFA);
      check_mf("mult");

      run_op(4'd4, 32'd7, 32'd2, "divu", 0);
      check("divu LO const", LO, 32'd3);
      check("divu HI const", HI, 32'd1);
      run_op(4'd3, 32'hFFFFFFF9, 32'd2, "div", 0);
      check("div LO const", LO, 32'hFFFFFFFD);
      check("div HI const", HI, 32'hFFFFFFFF);
      run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, "div_ovf", 0);
      check("div_ovf LO const", LO, 32'h80000000);
      check("div_ovf HI const", HI, 32'd0);

      run_op(4'd6, 32'hCAFEF00D, 32'd0, "mtlo", 0);
      run_op(4'd5, 32'h12345678, 32'd0, "mthi", 0);
      run_op(4'd3, 32'd5, 32'd0, "div0", 0);
      check("div0 HI const", HI, 32'h12345678);
      check("div0 LO const", LO, 32'hCAFEF00D);
      run_op(4'd4, 32'hDEADBEEF, 32'd0, "divu0", 0);

      // Asynchronous reset in the middle of a MULT, away from any clock edge
      start = 1'b1; op = 4'd1; A = 32'd1000; B = 32'd1000;
      @(negedge clk);
      start = 1'b0; op = 4'd0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("async_rst busy", {31'd0, busy}, 32'd0);
      check("async_rst HI", HI, 32'd0);
      check("async_rst LO", LO, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      m_hi  = 32'd0;
      m_lo  = 32'd0;
      repeat (8) @(negedge clk);
      check("post_rst busy", {31'd0, busy}, 32'd0);
      check("post_rst HI", HI, 32'd0);
      check_mf("post_rst");

      run_op(4'd2, 32'h00012345, 32'h00067890, "multu_inject", 2);
      run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_b2b", 0);
      check("b2b HI const", HI, 32'hFFFFFFFE);
      check("b2b LO const", LO, 32'h00000001);
      run_op(4'd7, 32'h11111111, 32'h22222222, "mfhi_start", 0);

`ifdef MDU_MADD_EN
      run_op(4'd5, 32'd0, 32'd0, "madd_mthi", 0);
      run_op(4'd6, 32'hFFFFFFFF, 32'd0, "madd_mtlo", 0);
      run_op(4'd10, 32'd1, 32'd1, "maddu", 0);
      check("maddu HI const", HI, 32'd1);
      check("maddu LO const", LO, 32'd0);
      run_op(4'd11, 32'hFFFFFFFF, 32'd3, "msub", 0);
      run_op(4'd9, 32'h80000000, 32'h7FFFFFFF, "madd", 0);
      run_op(4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, "msubu", 0);
`else
      run_op(4'd9, 32'd1, 32'd1, "op9_nop", 0);
`endif
      run_op(4'd15, 32'd9, 32'd9, "op15_nop", 0);

      for (int i = 0; i < 40; i++) begin
         ro = 4'($urandom_range(1, 8));
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
         run_op(ro, ra, rb, "rand", 0);
         if (i % 8 == 0) check_mf("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
